// File: rtl/stack_sequencer_if.sv
// rtl/stack_sequencer_if.sv - data-memory port between the stack sequencer and memory
interface stack_sequencer_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - multi-cycle PUSH/POP engine walking a register mask over data memory
module stack_sequencer #(
    parameter logic [31:0] SP_LOW  = 32'h0000_0000,
    parameter logic [31:0] SP_HIGH = 32'h0000_1000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic                     op_pop,
    input  logic [7:0]               op_mask,
    input  logic [31:0]              re_sp,
    output logic [2:0]               read_usr_addr,
    input  logic [31:0]              re_usr,
    output logic                     wr_usr_enable,
    output logic [2:0]               write_usr_addr,
    output logic [31:0]              usr_data,
    output logic                     wr_sp,
    output logic [31:0]              wr_sp_data,
    stack_sequencer_if.master        mem,
    output logic                     done,
    output logic                     fault
);
    typedef enum logic [1:0] {IDLE, XFER, SPWB, FAULT} state_t;

    state_t      state;
    logic        pop;
    logic [7:0]  m;
    logic [31:0] sp_w;
    logic [2:0]  cur_idx;

    logic [7:0]  m_in;
    logic [7:0]  m_nx;
    logic [3:0]  n_in;
    logic [32:0] span;
    logic        bound_fault;
    logic [2:0]  first_idx;
    logic [2:0]  next_idx;
    logic [31:0] sp_nx;

    function automatic logic [2:0] hi_bit(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    function automatic logic [2:0] lo_bit(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
        return r;
    endfunction

    function automatic logic [3:0] pop_count(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) c = c + {3'd0, v[i]};
        return c;
    endfunction

    // Bounds use 33-bit arithmetic so a PUSH near address 0 cannot wrap past the check.
    always_comb begin
        m_in        = op_mask & 8'hEF;
        n_in        = pop_count(m_in);
        span        = {27'd0, n_in, 2'b00};
        bound_fault = op_pop ? (({1'b0, re_sp} + span) > {1'b0, SP_HIGH})
                             : ({1'b0, re_sp} < ({1'b0, SP_LOW} + span));
        first_idx   = op_pop ? lo_bit(m_in) : hi_bit(m_in);
        m_nx        = m & ~(8'b1 << cur_idx);
        next_idx    = pop ? lo_bit(m_nx) : hi_bit(m_nx);
        sp_nx       = pop ? (sp_w + 32'd4) : (sp_w - 32'd4);
    end

    assign mem.wdata = re_usr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            op_ready       <= 1'b1;
            pop            <= 1'b0;
            m              <= 8'd0;
            sp_w           <= 32'd0;
            cur_idx        <= 3'd0;
            read_usr_addr  <= 3'd0;
            wr_usr_enable  <= 1'b0;
            write_usr_addr <= 3'd0;
            usr_data       <= 32'd0;
            wr_sp          <= 1'b0;
            wr_sp_data     <= 32'd0;
            mem.req        <= 1'b0;
            mem.we         <= 1'b0;
            mem.addr       <= 32'd0;
            done           <= 1'b0;
            fault          <= 1'b0;
        end else begin
            wr_usr_enable <= 1'b0;
            wr_sp         <= 1'b0;
            done          <= 1'b0;
            fault         <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid && op_ready) begin
                        pop      <= op_pop;
                        m        <= m_in;
                        sp_w     <= re_sp;
                        op_ready <= 1'b0;
                        if (bound_fault) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else if (m_in == 8'd0) begin
                            state      <= SPWB;
                            wr_sp      <= 1'b1;
                            wr_sp_data <= re_sp;
                            done       <= 1'b1;
                        end else begin
                            state    <= XFER;
                            cur_idx  <= first_idx;
                            mem.req  <= 1'b1;
                            mem.we   <= ~op_pop;
                            mem.addr <= op_pop ? re_sp : (re_sp - 32'd4);
                            if (!op_pop) read_usr_addr <= first_idx;
                        end
                    end
                end
                XFER: begin
                    if (mem.ack) begin
                        m    <= m_nx;
                        sp_w <= sp_nx;
                        if (pop) begin
                            wr_usr_enable  <= 1'b1;
                            write_usr_addr <= cur_idx;
                            usr_data       <= mem.rdata;
                        end
                        if (m_nx != 8'd0) begin
                            cur_idx  <= next_idx;
                            mem.addr <= pop ? sp_nx : (sp_nx - 32'd4);
                            if (!pop) read_usr_addr <= next_idx;
                        end else begin
                            state      <= SPWB;
                            mem.req    <= 1'b0;
                            mem.we     <= 1'b0;
                            wr_sp      <= 1'b1;
                            wr_sp_data <= sp_nx;
                            done       <= 1'b1;
                        end
                    end
                end
                SPWB, FAULT: begin
                    state    <= IDLE;
                    op_ready <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    op_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
